math_accumulator: RTL
=====================

Name: math_accumulator

Overview:
- Downstream consumer of the combinational math_operators block.
- Takes one of its three results (sum s, difference d or product p) and accumulates a burst of COUNT samples into a wide register.
- Uses a valid/ready input handshake and a valid/ready result handshake.
- Lets the arithmetic unit drive a dot-product or running-sum datapath in the logic-design exercises.

Parameters:
- WIDTH, 4, operand width of math_operators; s and d are WIDTH bits, p is 2*WIDTH bits.
- COUNT, 4, samples accumulated per burst; must be >= 1.
- ACC_WIDTH, 12, accumulator width; must be >= 2*WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
- op  input  2  operand select, captured at start: 00=s, 01=d, 10=p, 11=p.
- s  input  WIDTH  sum from math_operators.
- d  input  WIDTH  difference from math_operators.
- p  input  2*WIDTH  product from math_operators.
- in_valid  input  1  s/d/p hold a valid sample.
- in_ready  output  1  block accepts a sample this cycle.
- acc  output  ACC_WIDTH  accumulator value.
- out_valid  output  1  acc holds a completed burst result.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in RUN or DONE.
- overflow  output  1  sticky; an addition in the current burst exceeded ACC_WIDTH.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - acc, sample counter, captured op and overflow all cleared to 0.
  - in_ready=0, out_valid=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - acc and overflow hold the last burst's values.
  - start=1 -> RUN on next edge, with acc=0, counter=0, overflow=0, op latched.
- RUN:
  - in_ready=1, busy=1.
  - Accept when in_valid && in_ready. On the next edge:
    - acc <= acc + ext(selected operand), modulo 2^ACC_WIDTH.
    - counter increments.
  - Cycles without in_valid change nothing.
  - The accept with counter==COUNT-1 moves to DONE on the same edge.
- DONE:
  - in_ready=0, out_valid=1, busy=1; acc is stable.
  - out_ready=1 -> IDLE on next edge; out_valid drops, acc holds.
  - Without out_ready, stay in DONE indefinitely.
- Latency:
  - acc reflects an accepted sample one clock after acceptance.
  - out_valid rises on the same edge that adds the COUNT-th sample.
- Extension: operand zero-extended to ACC_WIDTH (see Optional Feature).
- Overflow: set when the unsigned add carries out of bit ACC_WIDTH-1. Sticky until the next start or reset; acc wraps.
- Boundary and simultaneous events:
  - start in RUN or DONE: ignored; the burst is not restarted.
  - start together with out_ready in DONE: handshake completes, start ignored.
  - in_valid in IDLE or DONE: ignored.
  - op change after start: no effect until the next start.
  - COUNT=1: one accept goes RUN->DONE.
  - reset mid-RUN: partial sum discarded; acc=0, back to IDLE.

Optional Feature:
- Macro: MATH_ACCUMULATOR_SIGNED_EN.
- Defined:
  - s, d, p treated as two's complement and sign-extended to ACC_WIDTH.
  - overflow = signed overflow: both addends share a sign and the result sign differs.
- Undefined:
  - zero-extension, unsigned carry-out overflow as above.
- Ports and state machine are identical in both builds.

Test Plan:
1. reset=1 mid-simulation with any inputs -> acc=0, in_ready=0, out_valid=0, busy=0, overflow=0 immediately, without waiting for a clock edge.
2. op=10, start, p=8'd225 on four consecutive cycles -> acc=900 (12'h384), out_valid=1 one edge after the 4th accept, overflow=0; out_ready=1 -> IDLE, acc stays 900.
3. op=00, s=3,5,7,9 with in_valid low on alternate cycles -> exactly 4 accepts, acc=24; start pulsed during RUN is ignored.
4. ACC_WIDTH=9, op=10, p=8'd255 x4 -> acc=508 (1020 mod 512), overflow=1; out_ready held low 5 cycles -> out_valid and acc held; next start clears overflow.
5. Reset asserted after 2 accepts of s=4 -> acc=0, IDLE. Fresh burst op=01, d=4'b1110 x4 -> acc=56 unsigned; with MATH_ACCUMULATOR_SIGNED_EN -> acc=12'hFF8 (-8), overflow=0.
6. COUNT=1, op=00, s=4'd15 -> RUN->DONE after a single accept, acc=15, out_valid=1.

Source files
------------

// File: rtl/math_accumulator.sv
// math_accumulator
//   Accumulates a burst of COUNT samples taken from one of the math_operators
//   results (sum s, difference d or product p) into an ACC_WIDTH register.
//   The source is selected by op, which is latched when the burst starts.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   start               : begin a burst (honoured only in IDLE)
//   op[1:0]             : 00=s, 01=d, 1x=p
//   s, d, p             : operands from math_operators
//   in_valid / in_ready : sample handshake (in_ready high only in RUN)
//   acc                 : accumulator value
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   busy                : high in RUN or DONE
//   overflow            : sticky overflow for the current/last burst
//
// Build option
//   MATH_ACCUMULATOR_SIGNED_EN : operands are sign-extended and overflow
//   reports signed overflow. Undefined: zero-extension, unsigned carry-out.
module math_accumulator #(
    parameter int WIDTH     = 4,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     d,
    input  logic [2*WIDTH-1:0]   p,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] s_ext, d_ext, p_ext, operand, sum;
    logic                 add_ovf;

`ifdef MATH_ACCUMULATOR_SIGNED_EN
    assign s_ext = ACC_WIDTH'($signed(s));
    assign d_ext = ACC_WIDTH'($signed(d));
    assign p_ext = ACC_WIDTH'($signed(p));
`else
    assign s_ext = ACC_WIDTH'(s);
    assign d_ext = ACC_WIDTH'(d);
    assign p_ext = ACC_WIDTH'(p);
`endif

    always_comb begin
        case (op_q)
            2'b00:   operand = s_ext;
            2'b01:   operand = d_ext;
            default: operand = p_ext;
        endcase
    end

`ifdef MATH_ACCUMULATOR_SIGNED_EN
    // Signed overflow: addends agree in sign but the result does not.
    assign sum     = acc_q + operand;
    assign add_ovf = (acc_q[ACC_WIDTH-1] == operand[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
`else
    logic [ACC_WIDTH:0] sum_ext;
    assign sum_ext = {1'b0, acc_q} + {1'b0, operand};
    assign sum     = sum_ext[ACC_WIDTH-1:0];
    assign add_ovf = sum_ext[ACC_WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    op_d    = op;
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_ovf;
                    // Last sample of the burst: result is valid on this edge.
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them at once.
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc       = acc_q;
    assign overflow  = ovf_q;

endmodule
